// File: rtl/div_recon_mul.sv
// Reconstructs a dividend n = q*d + r with an 8-step shift-add multiplier behind a valid/ready handshake.
// Optional error-check outputs (n_ref/err/err_dist) are enabled by defining DIV_RECON_ERRCHK_EN.
module div_recon_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  q,
    input  logic [7:0]  d,
    input  logic [7:0]  r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] n
`ifdef DIV_RECON_ERRCHK_EN
    ,
    input  logic [15:0] n_ref,
    output logic        err,
    output logic [15:0] err_dist
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] acc_r, acc_s;
    logic [15:0] mcand_r, mcand_s;
    logic [15:0] sum_s;
    logic [7:0]  mplier_r, mplier_s;
    logic [2:0]  cnt_r, cnt_s;
    logic        in_ready_r, in_ready_s;
    logic        out_valid_r, out_valid_s;
    logic [15:0] n_r, n_s;

`ifdef DIV_RECON_ERRCHK_EN
    logic [15:0] n_ref_r, n_ref_s;
    logic        err_r, err_s;
    logic [15:0] err_dist_r, err_dist_s;

    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] res;
        if (a >= b) begin
            res = a - b;
        end else begin
            res = b - a;
        end
        return res;
    endfunction
`endif

    // Next-state, datapath step and registered-output next values
    always_comb begin
        state_s     = state_r;
        acc_s       = acc_r;
        mcand_s     = mcand_r;
        mplier_s    = mplier_r;
        cnt_s       = cnt_r;
        in_ready_s  = in_ready_r;
        out_valid_s = out_valid_r;
        n_s         = n_r;
        sum_s       = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
`ifdef DIV_RECON_ERRCHK_EN
        n_ref_s     = n_ref_r;
        err_s       = err_r;
        err_dist_s  = err_dist_r;
`endif
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_s    = MUL;
                    acc_s      = {8'h00, r};
                    mcand_s    = {8'h00, d};
                    mplier_s   = q;
                    cnt_s      = 3'd0;
                    in_ready_s = 1'b0;
`ifdef DIV_RECON_ERRCHK_EN
                    n_ref_s    = n_ref;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            MUL: begin
                acc_s    = sum_s;
                mcand_s  = {mcand_r[14:0], 1'b0};
                mplier_s = {1'b0, mplier_r[7:1]};
                cnt_s    = cnt_r + 3'd1;
                // The eighth step's sum is published directly so n appears with out_valid
                if (cnt_r == 3'd7) begin
                    state_s     = DONE;
                    out_valid_s = 1'b1;
                    n_s         = sum_s;
`ifdef DIV_RECON_ERRCHK_EN
                    err_s       = (sum_s != n_ref_r);
                    err_dist_s  = abs_diff(n_ref_r, sum_s);
`endif
                end else begin
                    state_s = MUL;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_s     = IDLE;
                    out_valid_s = 1'b0;
                    in_ready_s  = 1'b1;
                    n_s         = 16'h0000;
`ifdef DIV_RECON_ERRCHK_EN
                    err_s       = 1'b0;
                    err_dist_s  = 16'h0000;
`endif
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s     = IDLE;
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
                n_s         = 16'h0000;
`ifdef DIV_RECON_ERRCHK_EN
                err_s       = 1'b0;
                err_dist_s  = 16'h0000;
`endif
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= 16'h0000;
            mcand_r     <= 16'h0000;
            mplier_r    <= 8'h00;
            cnt_r       <= 3'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            n_r         <= 16'h0000;
`ifdef DIV_RECON_ERRCHK_EN
            n_ref_r     <= 16'h0000;
            err_r       <= 1'b0;
            err_dist_r  <= 16'h0000;
`endif
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            mcand_r     <= mcand_s;
            mplier_r    <= mplier_s;
            cnt_r       <= cnt_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            n_r         <= n_s;
`ifdef DIV_RECON_ERRCHK_EN
            n_ref_r     <= n_ref_s;
            err_r       <= err_s;
            err_dist_r  <= err_dist_s;
`endif
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign n         = n_r;
`ifdef DIV_RECON_ERRCHK_EN
    assign err       = err_r;
    assign err_dist  = err_dist_r;
`endif

endmodule

// File: doc/div_recon_mul.md
DIV_RECON_MUL -- requirements
Module: div_recon_mul

Interface
REQ-001 The module SHALL have ports clk, input, 1, rising-edge clock, the module's only clock.
REQ-002 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 The module SHALL have port in_valid, input, 1, marking q/d/r as valid.
REQ-004 The module SHALL have port in_ready, output, 1, indicating the block accepts a new operand set.
REQ-005 The module SHALL have port q, input, 8, quotient.
REQ-006 The module SHALL have port d, input, 8, divisor.
REQ-007 The module SHALL have port r, input, 8, remainder.
REQ-008 The module SHALL have port out_valid, output, 1, marking n as a valid result.
REQ-009 The module SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 The module SHALL have port n, output, 16, the reconstructed dividend q*d+r.

Function
REQ-011 The module SHALL implement a three-state FSM:
- IDLE: in_ready=1, out_valid=0.
- MUL: in_ready=0, out_valid=0.
- DONE: in_ready=0, out_valid=1.
REQ-012 IDLE SHALL go to MUL on (in_valid & in_ready) at a clock edge. On that edge it SHALL latch:
- acc = {8'h00, r};
- mcand = {8'h00, d};
- mplier = q;
- cnt = 0.
REQ-013 Each MUL edge SHALL perform one shift-add step:
- if mplier[0]=1, acc = acc + mcand (16-bit);
- mcand shifts left 1;
- mplier shifts right 1;
- cnt increments.
REQ-014 MUL SHALL go to DONE on the edge where cnt reaches 7, i.e. after exactly 8 iterations. The result SHALL be visible 8 cycles after the accept edge, with fixed latency regardless of operand values.
REQ-015 n SHALL equal acc[15:0] and SHALL remain stable while out_valid=1. n SHALL be 16'h0000 outside DONE.
REQ-016 The max result is 255*255+255 = 65280. A 16-bit accumulator therefore SHALL never overflow, and no overflow flag exists.
REQ-017 DONE SHALL go to IDLE on (out_valid & out_ready). out_valid SHALL stay asserted, with n held, for any number of cycles with out_ready=0.
REQ-018 in_valid during MUL or DONE SHALL be ignored. No operand SHALL be captured outside IDLE, and there is no back-to-back bypass.
REQ-019 d=0 SHALL yield n={8'h00,r}. q=0 SHALL yield the same.
REQ-020 Unsigned arithmetic only. r>=d is not checked and SHALL be reconstructed arithmetically as given.

Reset
REQ-021 Asserting rst SHALL immediately force:
- state IDLE;
- in_ready=1, out_valid=0, n=0;
- acc, mcand, mplier, cnt = 0.
REQ-022 rst asserted mid-MUL or mid-DONE SHALL abort the operation with no result emitted. The first operation accepted after deassertion SHALL complete normally.

Configuration
REQ-023 With macro DIV_RECON_ERRCHK_EN defined, the module SHALL add these ports:
- input n_ref[15:0], latched with q/d/r at accept;
- output err, 1 bit;
- output err_dist, 16 bits.
REQ-024 With DIV_RECON_ERRCHK_EN defined, during DONE the outputs SHALL be err = (n != n_ref) and err_dist = |n_ref - n|. Outside DONE both SHALL be 0, and both SHALL be reset to 0. These outputs quantify the error of approximate divider arrays.
REQ-025 Without DIV_RECON_ERRCHK_EN, those ports and their registers SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-026 Basic operation: q=8'h12, d=8'h0A, r=8'h03 accepted with out_ready=1 -> out_valid high 8 cycles later, n=16'h00B7, back to IDLE next edge.
REQ-027 Maximum operands: q=8'hFF, d=8'hFF, r=8'hFE -> n=16'hFEFF with no wrap.
REQ-028 Zero divisor and backpressure: d=8'h00, q=8'h37, r=8'h05, out_ready held 0 for 5 cycles -> n=16'h0005 stable, out_valid held, in_valid pulses ignored. Releasing out_ready -> IDLE.
REQ-029 Reset mid-operation: rst pulsed 3 cycles after accept -> outputs 0 at once, no out_valid. Then q=2, d=3, r=1 -> n=16'h0007.
REQ-030 With DIV_RECON_ERRCHK_EN defined: q=8'h12, d=8'h0A, r=8'h03, n_ref=16'h00B8 -> err=1, err_dist=16'h0001. With n_ref=16'h00B7 -> err=0, err_dist=0.
